// File: rtl/if_stage_pkg.sv
// Shared definitions for the RV32I instruction-fetch stage: bus widths, reset PC,
// next-PC select encoding and small PC helpers.
`ifndef IF_STAGE_DEFINES
`define IF_STAGE_DEFINES
`define IF_TO_ID_BUS_WIDTH 64
`define EX_TO_IF_BUS_WIDTH 33
`define RESET_PC 32'h0000_0000
`endif

package if_stage_pkg;

    localparam logic [31:0] INSN_BYTES = 32'd4;

    typedef enum logic [1:0] {
        NPC_HOLD,
        NPC_SEQ,
        NPC_BRANCH,
        NPC_TRAP
    } npc_sel_e;

    function automatic logic [31:0] pc_next_seq(input logic [31:0] pc);
        return pc + INSN_BYTES;
    endfunction

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_npc_mux.sv
// Priority next-PC select for the fetch stage: trap/mret, then taken branch,
// then sequential advance on a transfer, otherwise hold.
module if_npc_mux
    import if_stage_pkg::*;
(
    input  logic [31:0] fetch_pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        trap_redirect,
    input  logic [31:0] trap_target,
    input  logic        xfer,
    output npc_sel_e    npc_sel,
    output logic [31:0] next_pc
);

    always_comb begin
        npc_sel = NPC_HOLD;
        next_pc = fetch_pc;
        if (trap_redirect) begin
            npc_sel = NPC_TRAP;
            next_pc = trap_target;
        end else if (br_taken) begin
            npc_sel = NPC_BRANCH;
            next_pc = br_target;
        end else if (xfer) begin
            npc_sel = NPC_SEQ;
            next_pc = pc_next_seq(fetch_pc);
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns fetch PC, addresses the synchronous ROM and hands
// {pc4, pc} to decode. Optional IF_MISALIGN_CHECK_EN adds a fetch_misalign output.
`ifndef IF_STAGE_DEFINES
`define IF_STAGE_DEFINES
`define IF_TO_ID_BUS_WIDTH 64
`define EX_TO_IF_BUS_WIDTH 33
`define RESET_PC 32'h0000_0000
`endif

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = `RESET_PC
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [`EX_TO_IF_BUS_WIDTH-1:0] ex_to_if_bus,
    input  logic                           trap_redirect,
    input  logic [31:0]                    trap_target,
    input  logic                           id_allow_in,
    output logic [31:0]                    irom_addr,
    output logic [`IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus,
    output logic                           if_to_id_valid
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic                           fetch_misalign
`endif
);

    logic [31:0] fetch_pc;
    logic [31:0] id_pc_hold;
    logic        if_valid;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fetch_ok;
    logic        xfer;
    npc_sel_e    npc_sel;
    logic [31:0] next_pc;

    assign {br_taken, br_target} = ex_to_if_bus;

`ifdef IF_MISALIGN_CHECK_EN
    assign fetch_ok = !pc_misaligned(fetch_pc);
`else
    assign fetch_ok = 1'b1;
`endif

    // Any redirect kills the wrong-path instruction in the same cycle.
    assign if_to_id_valid = rst_n && if_valid && !br_taken && !trap_redirect && fetch_ok;
    assign xfer           = if_to_id_valid && id_allow_in;
    assign if_to_id_bus   = {pc_next_seq(fetch_pc), fetch_pc};

    // Decode reads ROM data against its latched PC, so a stall re-reads id_pc_hold.
    assign irom_addr = !rst_n ? RESET_PC : (xfer ? fetch_pc : id_pc_hold);

    if_npc_mux u_npc_mux (
        .fetch_pc      (fetch_pc),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .trap_redirect (trap_redirect),
        .trap_target   (trap_target),
        .xfer          (xfer),
        .npc_sel       (npc_sel),
        .next_pc       (next_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            id_pc_hold <= RESET_PC;
            if_valid   <= 1'b0;
        end else begin
            if_valid <= 1'b1;
            case (npc_sel)
                NPC_TRAP, NPC_BRANCH: fetch_pc <= next_pc;
                NPC_SEQ: begin
                    fetch_pc   <= next_pc;
                    id_pc_hold <= fetch_pc;
                end
                default: ;
            endcase
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    // Sticky across branches; only a trap/mret or reset re-evaluates it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_misalign <= 1'b0;
        end else if (trap_redirect) begin
            fetch_misalign <= pc_misaligned(trap_target);
        end else if (br_taken) begin
            fetch_misalign <= fetch_misalign | pc_misaligned(br_target);
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed test-plan sequences and randomized
// stimulus, both compared every cycle against a behavioural fetch model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [32:0] ex_to_if_bus;
    logic        trap_redirect;
    logic [31:0] trap_target;
    logic        id_allow_in;
    logic [31:0] irom_addr;
    logic [63:0] if_to_id_bus;
    logic        if_to_id_valid;
`ifdef IF_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model of the fetch stage, written from the stage's rules.
    logic [31:0] m_pc;
    logic [31:0] m_hold;
    logic        m_started;
    logic        m_mis;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_to_if_bus   (ex_to_if_bus),
        .trap_redirect  (trap_redirect),
        .trap_target    (trap_target),
        .id_allow_in    (id_allow_in),
        .irom_addr      (irom_addr),
        .if_to_id_bus   (if_to_id_bus),
        .if_to_id_valid (if_to_id_valid)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs at the negedge, check outputs, then advance model on posedge.
    task automatic step(input logic allow, input logic br, input logic [31:0] bt,
                        input logic tr, input logic [31:0] tt);
        logic        e_valid;
        logic        e_xfer;
        logic [31:0] e_irom;
        id_allow_in   = allow;
        ex_to_if_bus  = {br, bt};
        trap_redirect = tr;
        trap_target   = tt;
        #1;
        e_valid = rst_n && m_started && !br && !tr;
`ifdef IF_MISALIGN_CHECK_EN
        if (m_pc[1:0] != 2'b00) e_valid = 1'b0;
        check("misalign", {63'd0, fetch_misalign}, {63'd0, m_mis});
`endif
        e_xfer = e_valid && allow;
        e_irom = !rst_n ? 32'd0 : (e_xfer ? m_pc : m_hold);
        check("valid", {63'd0, if_to_id_valid}, {63'd0, e_valid});
        check("bus", if_to_id_bus, {m_pc + 32'd4, m_pc});
        check("irom", {32'd0, irom_addr}, {32'd0, e_irom});
        @(posedge clk);
        if (!rst_n) begin
            m_pc = 32'd0; m_hold = 32'd0; m_started = 1'b0; m_mis = 1'b0;
        end else begin
            if (tr) begin
                m_pc = tt;
                m_mis = (tt[1:0] != 2'b00);
            end else if (br) begin
                m_pc = bt;
                m_mis = m_mis || (bt[1:0] != 2'b00);
            end else if (e_xfer) begin
                m_hold = m_pc;
                m_pc = m_pc + 32'd4;
            end
            m_started = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic go(input logic allow);
        step(allow, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        logic [31:0] cur;
        logic        r_br;
        logic        r_tr;
        logic [31:0] r_bt;
        logic [31:0] r_tt;
        rst_n = 1'b0;
        id_allow_in = 1'b1; ex_to_if_bus = '0; trap_redirect = 1'b0; trap_target = '0;
        m_pc = '0; m_hold = '0; m_started = 1'b0; m_mis = 1'b0;
        @(posedge clk);
        @(negedge clk);
        go(1'b1);
        go(1'b1);
        check("rst_valid", {63'd0, if_to_id_valid}, 64'd0);
        check("rst_irom", {32'd0, irom_addr}, 64'd0);
        rst_n = 1'b1;

        // Reset release: first cycle idle, then 0,4,8,12 back to back.
        go(1'b1);
        for (int unsigned i = 0; i < 4; i++) begin
            check("seq_pc", {32'd0, if_to_id_bus[31:0]}, 64'(i * 4));
            go(1'b1);
        end

        // Stall at 0x10: ROM re-reads decode's PC 0x0C.
        check("stall_pc", {32'd0, if_to_id_bus[31:0]}, 64'h10);
        id_allow_in = 1'b0;
        #1;
        check("stall_irom", {32'd0, irom_addr}, 64'h0C);
        for (int unsigned i = 0; i < 3; i++) go(1'b0);
        check("stall_hold", {32'd0, if_to_id_bus[31:0]}, 64'h10);
        go(1'b1);
        check("resume_pc", {32'd0, if_to_id_bus[31:0]}, 64'h14);
        go(1'b1); go(1'b1); go(1'b1);

        // Branch at 0x20 to 0x200.
        check("pre_br_pc", {32'd0, if_to_id_bus[31:0]}, 64'h20);
        step(1'b1, 1'b1, 32'h200, 1'b0, 32'd0);
        check("br_bus", if_to_id_bus, {32'h204, 32'h200});

        // Trap beats branch.
        step(1'b1, 1'b1, 32'h200, 1'b1, 32'h100);
        check("trap_prio", {32'd0, if_to_id_bus[31:0]}, 64'h100);

        // Redirect during stall.
        step(1'b0, 1'b1, 32'h300, 1'b0, 32'd0);
        for (int unsigned i = 0; i < 2; i++) begin
            check("redir_stall_pc", {32'd0, if_to_id_bus[31:0]}, 64'h300);
            go(1'b0);
        end
        go(1'b1);
        check("redir_resume", {32'd0, if_to_id_bus[31:0]}, 64'h304);

        // Redirect to the current PC still kills the cycle's instruction.
        cur = if_to_id_bus[31:0];
        step(1'b1, 1'b1, cur, 1'b0, 32'd0);
        check("self_redir_pc", {32'd0, if_to_id_bus[31:0]}, {32'd0, cur});

        // PC wrap at the top of the address space.
        step(1'b1, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
        check("wrap_pc4", {32'd0, if_to_id_bus[63:32]}, 64'd0);
        go(1'b1);
        check("wrap_next", {32'd0, if_to_id_bus[31:0]}, 64'd0);

`ifdef IF_MISALIGN_CHECK_EN
        step(1'b1, 1'b1, 32'h202, 1'b0, 32'd0);
        check("mis_set", {63'd0, fetch_misalign}, 64'd1);
        go(1'b1);
        check("mis_kill", {63'd0, if_to_id_valid}, 64'd0);
        step(1'b1, 1'b0, 32'd0, 1'b1, 32'h80);
        check("mis_clr", {63'd0, fetch_misalign}, 64'd0);
        check("mis_resume", {32'd0, if_to_id_bus[31:0]}, 64'h80);
        go(1'b1);
`endif

        // Randomized traffic, including occasional mid-stream resets.
        for (int unsigned i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            r_br  = ($urandom_range(0, 9) == 0);
            r_tr  = ($urandom_range(0, 19) == 0);
            r_bt  = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
            r_tt  = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
`ifdef IF_MISALIGN_CHECK_EN
            if ($urandom_range(0, 9) == 0) r_bt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) r_tt[1:0] = 2'($urandom_range(1, 3));
`endif
            step(($urandom_range(0, 9) < 7), r_br, r_bt, r_tr, r_tt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
